// File: rtl/sm83_irq_ctrl.sv
// SM83-style interrupt controller: IF/IE registers, IME enable sequencing with
// one-instruction EI delay, and a two-state dispatch handshake to the CPU core.
module sm83_irq_ctrl #(
  parameter int          N_SRC      = 5,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter logic [7:0]  VEC_STRIDE = 8'h08,
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_req,
  input  logic [15:0]      bus_addr,
  input  logic [7:0]       bus_wdata,
  input  logic             bus_we,
  output logic [7:0]       bus_rdata,
  output logic             bus_hit,
  input  logic             ei,
  input  logic             di,
  input  logic             reti,
  input  logic             instr_boundary,
  input  logic             int_ack,
  output logic             ime,
  output logic             int_pending,
  output logic             int_take,
  output logic [7:0]       int_vec
);

  typedef enum logic [1:0] {IME_OFF, IME_ARMED, IME_ON} ime_state_t;
  typedef enum logic {D_IDLE, D_REQ} disp_state_t;

  // Unimplemented IF bits read back as 1.
  localparam logic [7:0] IF_PAD = 8'(8'hFF << N_SRC);

  logic [N_SRC-1:0] if_q, if_d;
  logic [7:0]       ie_q, ie_d;
  ime_state_t       ime_q, ime_d;
  disp_state_t      disp_q, disp_d;
  logic [2:0]       idx_q, idx_d;

  logic             sel_if, sel_ie;
  logic [N_SRC-1:0] pend_vec;
  logic [2:0]       low_idx;
  logic             ack_fire;

  assign sel_if   = (bus_addr == IF_ADDR);
  assign sel_ie   = (bus_addr == IE_ADDR);
  assign pend_vec = ie_q[N_SRC-1:0] & if_q;
  assign ack_fire = int_ack && (disp_q == D_REQ);

  always_comb begin
    bus_hit   = sel_if || sel_ie;
    bus_rdata = 8'h00;
    if (sel_if)
      bus_rdata = IF_PAD | 8'(if_q);
    else if (sel_ie)
      bus_rdata = ie_q;
    int_pending = |pend_vec;
  end

  always_comb begin
    low_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend_vec[i])
        low_idx = 3'(i);
    end
  end

  // Per-bit priority: peripheral set beats dispatch clear beats bus write.
  always_comb begin
    if_d = if_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus_we && sel_if)
        if_d[i] = bus_wdata[i];
      if (ack_fire && (idx_q == 3'(i)))
        if_d[i] = 1'b0;
      if (irq_req[i])
        if_d[i] = 1'b1;
    end
    ie_d = (bus_we && sel_ie) ? bus_wdata : ie_q;
  end

  always_comb begin
    ime_d = ime_q;
    if (di)
      ime_d = IME_OFF;
    else if (reti)
      ime_d = IME_ON;
    else if (ack_fire)
      ime_d = IME_OFF;
    else if (ei) begin
      if (ime_q == IME_OFF)
        ime_d = IME_ARMED;
    end else if ((ime_q == IME_ARMED) && instr_boundary)
      ime_d = IME_ON;
  end

  always_comb begin
    disp_d = disp_q;
    idx_d  = idx_q;
    case (disp_q)
      D_IDLE: begin
        if (ime && int_pending && instr_boundary) begin
          disp_d = D_REQ;
          idx_d  = low_idx;
        end
      end
      D_REQ: begin
        if (int_ack)
          disp_d = D_IDLE;
      end
      default: disp_d = D_IDLE;
    endcase
  end

  always_comb begin
    ime      = (ime_q == IME_ON);
    int_take = (disp_q == D_REQ);
    int_vec  = int_take ? (VEC_BASE + 8'(idx_q) * VEC_STRIDE) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_q   <= '0;
      ie_q   <= 8'h00;
      ime_q  <= IME_OFF;
      disp_q <= D_IDLE;
      idx_q  <= 3'd0;
    end else begin
      if_q   <= if_d;
      ie_q   <= ie_d;
      ime_q  <= ime_d;
      disp_q <= disp_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Bench for sm83_irq_ctrl: two instances (5 and 8 sources) driven in lockstep and
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_sm83_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst, bus_we, ei, di, reti, bnd, ack;
  logic [7:0]  irq, bus_wdata;
  logic [15:0] bus_addr;

  logic [7:0] rd5, vec5, rd8, vec8;
  logic       hit5, ime5, pend5, take5, hit8, ime8, pend8, take8;

  always #5 clk = ~clk;

  sm83_irq_ctrl dut5 (
    .clk(clk), .rst(rst), .irq_req(irq[4:0]), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(rd5), .bus_hit(hit5),
    .ei(ei), .di(di), .reti(reti), .instr_boundary(bnd), .int_ack(ack),
    .ime(ime5), .int_pending(pend5), .int_take(take5), .int_vec(vec5)
  );

  sm83_irq_ctrl #(.N_SRC(8), .VEC_STRIDE(8'h20)) dut8 (
    .clk(clk), .rst(rst), .irq_req(irq), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(rd8), .bus_hit(hit8),
    .ei(ei), .di(di), .reti(reti), .instr_boundary(bnd), .int_ack(ack),
    .ime(ime8), .int_pending(pend8), .int_take(take8), .int_vec(vec8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: 0 = five sources, 1 = eight sources.
  int m_if[2], m_ie[2], m_on[2], m_arm[2], m_busy[2], m_idx[2];
  int mn[2]      = '{5, 8};
  int mstride[2] = '{8, 32};
  bit m_valid    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lowest(int v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic int exp_rdata(int k);
    int mask = (1 << mn[k]) - 1;
    if (bus_addr == 16'hFF0F) return (m_if[k] | ~mask) & 255;
    if (bus_addr == 16'hFFFF) return m_ie[k];
    return 0;
  endfunction

  function automatic int exp_pend(int k);
    return ((m_ie[k] & m_if[k]) != 0) ? 1 : 0;
  endfunction

  function automatic int exp_vec(int k);
    return m_busy[k] ? ((64 + m_idx[k] * mstride[k]) & 255) : 0;
  endfunction

  task automatic compare_all();
    int hit;
    if (!m_valid) return;
    hit = (bus_addr == 16'hFF0F || bus_addr == 16'hFFFF) ? 1 : 0;
    chk("rdata5", rd5, exp_rdata(0));  chk("rdata8", rd8, exp_rdata(1));
    chk("hit5", hit5, hit);            chk("hit8", hit8, hit);
    chk("ime5", ime5, m_on[0]);        chk("ime8", ime8, m_on[1]);
    chk("pend5", pend5, exp_pend(0));  chk("pend8", pend8, exp_pend(1));
    chk("take5", take5, m_busy[0]);    chk("take8", take8, m_busy[1]);
    chk("vec5", vec5, exp_vec(0));     chk("vec8", vec8, exp_vec(1));
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mask, nif, ackf;
      if (rst) begin
        m_if[k] = 0; m_ie[k] = 0; m_on[k] = 0; m_arm[k] = 0; m_busy[k] = 0; m_idx[k] = 0;
        continue;
      end
      mask = (1 << mn[k]) - 1;
      ackf = (ack && m_busy[k]) ? 1 : 0;
      nif  = m_if[k];
      if (bus_we && bus_addr == 16'hFF0F) nif = int'(bus_wdata) & mask;
      if (ackf) nif = nif & ~(1 << m_idx[k]);
      nif = nif | (int'(irq) & mask);
      if (!m_busy[k] && m_on[k] != 0 && exp_pend(k) != 0 && bnd) begin
        m_busy[k] = 1;
        m_idx[k]  = lowest(m_ie[k] & m_if[k]);
      end else if (m_busy[k] && ack)
        m_busy[k] = 0;
      if (di) begin
        m_on[k] = 0; m_arm[k] = 0;
      end else if (reti) begin
        m_on[k] = 1; m_arm[k] = 0;
      end else if (ackf) begin
        m_on[k] = 0; m_arm[k] = 0;
      end else if (ei) begin
        if (!m_on[k]) m_arm[k] = 1;
      end else if (m_arm[k] && bnd) begin
        m_on[k] = 1; m_arm[k] = 0;
      end
      if (bus_we && bus_addr == 16'hFFFF) m_ie[k] = int'(bus_wdata);
      m_if[k] = nif;
    end
    if (rst) m_valid = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; irq = 8'h00; bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 0;
    ei = 0; di = 0; reti = 0; bnd = 0; ack = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    idle(); bus_we = 1; bus_addr = a; bus_wdata = d; cycle();
  endtask

  initial begin
    idle();
    rst = 1; cycle();

    // Reset read-back.
    idle(); bus_addr = 16'hFF0F; #1;
    chk("rst_if5", rd5, 8'hE0); chk("rst_if8", rd8, 8'h00); chk("rst_take", take5, 1'b0);
    bus_addr = 16'hFFFF; #1;
    chk("rst_ie5", rd5, 8'h00); chk("rst_ime", ime5, 1'b0);
    cycle();

    // Two simultaneous requests, lower index dispatched first.
    wr(16'hFFFF, 8'h1F);
    idle(); irq = 8'h06; cycle();
    idle(); reti = 1; cycle();
    idle(); #1 chk("reti_ime", ime5, 1'b1);
    bnd = 1; cycle();
    idle(); #1 chk("take_a", take5, 1'b1); chk("vec_a", vec5, 8'h48);
    ack = 1; cycle();
    idle(); bus_addr = 16'hFF0F; #1;
    chk("ack_if", rd5, 8'hE4); chk("ack_ime", ime5, 1'b0); chk("ack_take", take5, 1'b0);
    cycle();

    // EI delay of one instruction.
    wr(16'hFF0F, 8'h01);
    wr(16'hFFFF, 8'h01);
    idle(); ei = 1; bnd = 1; cycle();
    idle(); #1 chk("ei_take", take5, 1'b0); chk("ei_ime", ime5, 1'b0);
    bnd = 1; cycle();
    idle(); #1 chk("ei_ime2", ime5, 1'b1); chk("ei_take2", take5, 1'b0);
    bnd = 1; cycle();
    idle(); #1 chk("ei_take3", take5, 1'b1); chk("ei_vec", vec5, 8'h40);
    ack = 1; cycle();

    // EI cancelled by DI.
    wr(16'hFF0F, 8'h01);
    idle(); ei = 1; cycle();
    idle(); di = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); bnd = 1; cycle();
      idle(); #1 chk("di_ime", ime5, 1'b0); chk("di_pend", pend5, 1'b1);
    end

    // Set beats bus write and dispatch clear.
    idle(); irq = 8'h08; bus_we = 1; bus_addr = 16'hFF0F; bus_wdata = 8'h00; cycle();
    idle(); bus_addr = 16'hFF0F; #1 chk("set_wr", rd5, 8'hE8);
    wr(16'hFFFF, 8'h08);
    idle(); reti = 1; cycle();
    idle(); bnd = 1; cycle();
    idle(); #1 chk("vec3", vec5, 8'h58);
    ack = 1; irq = 8'h08; cycle();
    idle(); bus_addr = 16'hFF0F; #1 chk("set_ack", rd5, 8'hE8); chk("set_ack_ime", ime5, 1'b0);
    cycle();

    // Vector wrap on eight sources, then reset during dispatch.
    wr(16'hFF0F, 8'h80);
    wr(16'hFFFF, 8'h80);
    idle(); reti = 1; cycle();
    idle(); bnd = 1; cycle();
    idle(); #1 chk("wrap_take", take8, 1'b1); chk("wrap_vec", vec8, 8'h20); chk("wrap_no5", take5, 1'b0);
    rst = 1; ack = 1; cycle();
    idle(); #1 chk("rst_req_take", take8, 1'b0); chk("rst_req_vec", vec8, 8'h00);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst  = ($urandom_range(199) == 0);
      irq  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus_we = ($urandom_range(4) == 0);
      case ($urandom_range(3))
        0, 1: bus_addr = 16'hFF0F;
        2:    bus_addr = 16'hFFFF;
        default: bus_addr = 16'($urandom);
      endcase
      bus_wdata = 8'($urandom);
      ei   = ($urandom_range(9) == 0);
      di   = ($urandom_range(14) == 0);
      reti = ($urandom_range(19) == 0);
      bnd  = ($urandom_range(1) == 0);
      ack  = ($urandom_range(3) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
